trail_backjump: RTL and testbench

Assignment trail for the CDCL engine: a LIFO of literal assignments, each tagged as decision or implied, paired with the decision-level counter. Pushes of decisions drive the counter up. On a conflict, a backjump request unwinds the trail down to a target level. Each popped assignment is streamed out to the variable store as an unassign command, and each popped decision drives the counter down.

---
 rtl/trail_backjump.sv | 147 ++++++++++++++
 tb/tb_trail_backjump.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trail_backjump.sv
// Assignment trail for the CDCL engine: LIFO of {var, val, decision} plus the decision-level
// counter; a backjump unwinds the trail to a target level, streaming out unassign commands.
module trail_backjump #(
  parameter int LITERALS = 8,
  localparam int VW = $clog2(LITERALS),
  localparam int CW = $clog2(LITERALS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [VW-1:0] push_var,
  input  logic          push_val,
  input  logic          push_decision,
  input  logic          bj_start,
  input  logic [VW-1:0] bj_level,
  output logic          bj_busy,
  output logic          bj_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_var,
  output logic          out_val,
  output logic          lvl_enable,
  output logic          lvl_incr,
  output logic [VW-1:0] level,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, UNWIND, DONE} state_t;

  localparam logic [VW-1:0] LVL_MAX = {VW{1'b1}};
  localparam logic [VW-1:0] LVL_ONE = VW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LITERALS);

  state_t        state, state_nxt;
  logic [VW-1:0] mem_var [LITERALS];
  logic          mem_val [LITERALS];
  logic          mem_dec [LITERALS];
  logic [VW-1:0] tgt;
  logic [VW-1:0] top_idx;
  logic [VW-1:0] wr_idx;
  logic          top_dec;
  logic          push_wr;
  logic          pop;

  assign top_idx = VW'(count - CNT_ONE);
  assign wr_idx  = VW'(count);
  assign top_dec = mem_dec[top_idx];
  assign out_var = mem_var[top_idx];
  assign out_val = mem_val[top_idx];
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign bj_busy = rst && (state != IDLE);

  always_comb begin
    state_nxt  = state;
    push_ready = 1'b0;
    out_valid  = 1'b0;
    bj_done    = 1'b0;
    lvl_enable = 1'b0;
    lvl_incr   = 1'b0;
    err        = 1'b0;
    push_wr    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        push_ready = !full && !bj_start;
        if (bj_start) begin
          state_nxt = (bj_level < level && !empty) ? UNWIND : DONE;
        end else if (push_valid && push_ready) begin
          // A decision beyond the widest representable level is dropped, not stored.
          if (push_decision && level == LVL_MAX) begin
            err = 1'b1;
          end else begin
            push_wr    = 1'b1;
            lvl_enable = push_decision;
            lvl_incr   = push_decision;
          end
        end
      end
      UNWIND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pop        = 1'b1;
          lvl_enable = top_dec;
          if ((top_dec && (level - LVL_ONE) == tgt) || count == CNT_ONE) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        bj_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held every pulse and handshake is suppressed.
    if (!rst) begin
      push_ready = 1'b0;
      out_valid  = 1'b0;
      bj_done    = 1'b0;
      lvl_enable = 1'b0;
      lvl_incr   = 1'b0;
      err        = 1'b0;
      push_wr    = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      level <= '0;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bj_start) begin
        tgt <= bj_level;
      end
      if (push_wr) begin
        count <= count + CNT_ONE;
        if (push_decision) begin
          level <= level + LVL_ONE;
        end
      end else if (pop) begin
        count <= count - CNT_ONE;
        if (top_dec) begin
          level <= level - LVL_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_wr) begin
      mem_var[wr_idx] <= push_var;
      mem_val[wr_idx] <= push_val;
      mem_dec[wr_idx] <= push_decision;
    end
  end

endmodule

// File: tb/tb_trail_backjump.sv
// Directed and random checks of trail_backjump against a queue-based reference of the trail.
module tb_trail_backjump;

  localparam int LIT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0, push_val = 1'b0, push_decision = 1'b0;
  logic [2:0] push_var = '0;
  logic       bj_start = 1'b0;
  logic [2:0] bj_level = '0;
  logic       out_ready = 1'b0;
  logic       push_ready, bj_busy, bj_done, out_valid, out_val;
  logic       lvl_enable, lvl_incr, full, empty, err;
  logic [2:0] out_var, level;
  logic [3:0] count;

  trail_backjump #(.LITERALS(LIT)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_var(push_var),
    .push_val(push_val), .push_decision(push_decision),
    .bj_start(bj_start), .bj_level(bj_level), .bj_busy(bj_busy), .bj_done(bj_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_var(out_var), .out_val(out_val),
    .lvl_enable(lvl_enable), .lvl_incr(lvl_incr), .level(level), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int v; bit val; bit dec;} ent_t;
  localparam int MS_IDLE = 0, MS_UNWIND = 1, MS_DONE = 2;

  ent_t q[$];
  int   mlevel = 0;
  int   ms = MS_IDLE;
  int   mtgt = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   last_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mlevel = 0;
    ms = MS_IDLE;
    mtgt = 0;
  endtask

  task automatic chk_regs();
    chk("count", 32'(count), 32'(q.size()));
    chk("level", 32'(level), 32'(mlevel));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == LIT));
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registers.
  task automatic cyc(input bit pv, input int pvar, input bit pval, input bit pdec,
                     input bit bs, input int bl, input bit ordy);
    bit e_pr, e_ov, e_en, e_inc, e_err, e_done, acc, rej;
    ent_t e;
    push_valid = pv; push_var = 3'(pvar); push_val = pval; push_decision = pdec;
    bj_start = bs; bj_level = 3'(bl); out_ready = ordy;
    #1;
    e_pr = 0; e_ov = 0; e_en = 0; e_inc = 0; e_err = 0; e_done = 0; acc = 0; rej = 0;
    if (ms == MS_IDLE) begin
      e_pr = (q.size() < LIT) && !bs;
      acc = pv && e_pr;
      rej = acc && pdec && (mlevel == 7);
      e_err = rej;
      e_en = acc && pdec && !rej;
      e_inc = e_en;
    end else if (ms == MS_UNWIND) begin
      e_ov = 1;
      e_en = ordy && q[q.size()-1].dec;
      chk("out_var", 32'(out_var), 32'(q[q.size()-1].v));
      chk("out_val", 32'(out_val), 32'(q[q.size()-1].val));
    end else begin
      e_done = 1;
    end
    chk("push_ready", 32'(push_ready), 32'(e_pr));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("lvl_enable", 32'(lvl_enable), 32'(e_en));
    chk("lvl_incr", 32'(lvl_incr), 32'(e_inc));
    chk("err", 32'(err), 32'(e_err));
    chk("bj_done", 32'(bj_done), 32'(e_done));
    chk("bj_busy", 32'(bj_busy), 32'(ms != MS_IDLE));
    last_done = bj_done;
    @(posedge clk);
    case (ms)
      MS_IDLE: begin
        if (bs) begin
          if (bl < mlevel && q.size() > 0) begin ms = MS_UNWIND; mtgt = bl; end
          else ms = MS_DONE;
        end else if (acc && !rej) begin
          q.push_back('{v: pvar & 7, val: pval, dec: pdec});
          if (pdec) mlevel++;
        end
      end
      MS_UNWIND: begin
        if (ordy) begin
          e = q.pop_back();
          if (e.dec) mlevel--;
          if ((e.dec && mlevel == mtgt) || q.size() == 0) ms = MS_DONE;
        end
      end
      default: ms = MS_IDLE;
    endcase
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    push_valid = 0; bj_start = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_push_ready", 32'(push_ready), 32'd0);
    chk("rst_busy", 32'(bj_busy), 32'd0);
    chk("rst_done", 32'(bj_done), 32'd0);
    chk("rst_lvl_enable", 32'(lvl_enable), 32'd0);
    chk_regs();
    rst = 1'b1;
    #1;
    chk("post_rst_push_ready", 32'(push_ready), 32'd1);
  endtask

  // Backjump with the first `stall` unwind cycles holding out_ready low; checks bj_done latency.
  task automatic run_bj(input int bl, input int stall);
    int need, pops, k, t, done_at;
    pops = 0;
    if (bl < mlevel && q.size() > 0) begin
      need = mlevel - bl;
      for (int i = q.size() - 1; i >= 0 && need > 0; i--) begin
        pops++;
        if (q[i].dec) need--;
      end
    end
    done_at = -1;
    cyc(0, 0, 0, 0, 1, bl, 1);
    k = 0; t = 0;
    while (ms != MS_IDLE && k < 40) begin
      cyc(0, 0, 0, 0, 0, 0, (t < stall) ? 1'b0 : 1'b1);
      t++; k++;
      if (last_done) done_at = k;
    end
    chk("bj_terminates", 32'(ms), 32'(MS_IDLE));
    chk("bj_latency", 32'(done_at), 32'(pops + 1 + ((pops > 0) ? stall : 0)));
  endtask

  initial begin
    do_reset();

    cyc(1, 3, 1, 1, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 6, 1, 0, 0, 0, 0);
    chk("seq_level", 32'(level), 32'd2);
    chk("seq_count", 32'(count), 32'd4);

    run_bj(1, 0);
    chk("bj1_level", 32'(level), 32'd1);
    chk("bj1_count", 32'(count), 32'd2);

    // No-op backjump with a competing push that must be refused.
    cyc(1, 2, 0, 1, 0, 0, 0);
    cyc(1, 7, 1, 1, 1, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("noop_count", 32'(count), 32'd3);

    cyc(1, 4, 0, 0, 0, 0, 0);
    run_bj(0, 3);
    chk("bp_level", 32'(level), 32'd0);

    // Full trail, refused ninth push, reset mid-unwind.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, i, i % 2, (i % 2) == 0, 0, 0, 0);
    chk("full_flag", 32'(full), 32'd1);
    cyc(1, 7, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("midrst_done", 32'(bj_done), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    model_clear();
    chk_regs();
    chk("midrst_busy", 32'(bj_busy), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_after_done", 32'(bj_done), 32'd0);

    // Eight decisions from empty: the last one overflows the level and is rejected.
    for (int i = 0; i < 8; i++) cyc(1, i, 1, 1, 0, 0, 0);
    chk("ovf_level", 32'(level), 32'd7);
    cyc(1, 2, 0, 0, 0, 0, 0);
    run_bj(3, 1);

    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 9) == 0, $urandom_range(0, 7),
          $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
